// File: rtl/shift_issue_queue.sv
// Two-entry issue queue in front of a MIPS shifter stage.
// Decodes shift instructions (sll/srl/rotr/sra/sllv/srlv/rotrv/srav) into
// {data, count, op, rd} entries; anything else is dropped and counted.
module shift_issue_queue #(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 5,
    parameter logic [1:0] lo_l       = 2'd0,
    parameter logic [1:0] lo_r       = 2'd1,
    parameter logic [1:0] al_r       = 2'd2,
    parameter logic [1:0] ci_r       = 2'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_count,
    output logic [1:0]            out_op,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic                  illegal_pulse,
    output logic [7:0]            illegal_cnt
);

    logic                  dec_legal;
    logic [1:0]            dec_op;
    logic [ADDR_WIDTH-1:0] dec_count;
    logic [ADDR_WIDTH-1:0] dec_rd;

    logic [DATA_WIDTH-1:0] data_mem  [2];
    logic [ADDR_WIDTH-1:0] count_mem [2];
    logic [1:0]            op_mem    [2];
    logic [ADDR_WIDTH-1:0] rd_mem    [2];

    logic [1:0] occ;
    logic       wr_ptr;
    logic       rd_ptr;
    logic       accept;
    logic       push;
    logic       pop;

    // Instruction fields that never influence the decode; collected so they read as intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{instr[25:22], instr[20:16], rs_val[DATA_WIDTH-1:5]};

    // Decode the instruction into shifter op and shift amount; only SPECIAL-opcode shift functs are legal.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = lo_l;
        dec_count = '0;
        dec_rd    = ADDR_WIDTH'(instr[15:11]);
        if (instr[31:26] == 6'd0) begin
            case (instr[5:0])
                6'b000000: begin
                    dec_legal = 1'b1;
                    dec_op    = lo_l;
                    dec_count = ADDR_WIDTH'(instr[10:6]);
                end
                6'b000010: begin
                    dec_legal = 1'b1;
                    dec_op    = instr[21] ? ci_r : lo_r;
                    dec_count = ADDR_WIDTH'(instr[10:6]);
                end
                6'b000011: begin
                    dec_legal = 1'b1;
                    dec_op    = al_r;
                    dec_count = ADDR_WIDTH'(instr[10:6]);
                end
                6'b000100: begin
                    dec_legal = 1'b1;
                    dec_op    = lo_l;
                    dec_count = ADDR_WIDTH'(rs_val[4:0]);
                end
                6'b000110: begin
                    dec_legal = 1'b1;
                    dec_op    = instr[6] ? ci_r : lo_r;
                    dec_count = ADDR_WIDTH'(rs_val[4:0]);
                end
                6'b000111: begin
                    dec_legal = 1'b1;
                    dec_op    = al_r;
                    dec_count = ADDR_WIDTH'(rs_val[4:0]);
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Handshakes: illegal instructions still take an accept slot but never write storage.
    assign in_ready  = (occ != 2'd2) && !rst;
    assign out_valid = (occ != 2'd0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && dec_legal;
    assign pop       = out_valid && out_ready;

    // Head entry is presented directly; an empty queue shows all zeros.
    assign out_data  = out_valid ? data_mem[rd_ptr]  : '0;
    assign out_count = out_valid ? count_mem[rd_ptr] : '0;
    assign out_op    = out_valid ? op_mem[rd_ptr]    : '0;
    assign out_rd    = out_valid ? rd_mem[rd_ptr]    : '0;

    // FIFO storage, pointers and occupancy; pop and push on the same edge keep occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_mem[i]  <= '0;
                count_mem[i] <= '0;
                op_mem[i]    <= '0;
                rd_mem[i]    <= '0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr]  <= rt_val;
                count_mem[wr_ptr] <= dec_count;
                op_mem[wr_ptr]    <= dec_op;
                rd_mem[wr_ptr]    <= dec_rd;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Rejected-instruction flag (one cycle after acceptance) and saturating rejection counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_pulse <= 1'b0;
            illegal_cnt   <= 8'd0;
        end else begin
            illegal_pulse <= accept && !dec_legal;
            if (accept && !dec_legal && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_queue.sv
// Self-checking bench for shift_issue_queue: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_shift_issue_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_count;
    logic [1:0]  out_op;
    logic [4:0]  out_rd;
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  count;
        logic [1:0]  op;
        logic [4:0]  rd;
    } entry_t;

    entry_t     m_q[$];
    logic       m_pulse;
    int         m_cnt;
    int         n_cmp;
    int         n_fail;

    shift_issue_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_op(out_op), .out_rd(out_rd),
        .illegal_pulse(illegal_pulse), .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the instruction-set rules.
    function automatic void ref_decode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt,
                                       output logic legal, output entry_t e);
        legal   = 1'b1;
        e.data  = rt;
        e.rd    = w[15:11];
        e.count = w[10:6];
        e.op    = 2'd0;
        if (w[31:26] != 6'd0) legal = 1'b0;
        else begin
            case (w[5:0])
                6'd0: e.op = 2'd0;
                6'd2: e.op = w[21] ? 2'd3 : 2'd1;
                6'd3: e.op = 2'd2;
                6'd4: begin e.op = 2'd0; e.count = rs[4:0]; end
                6'd6: begin e.op = w[6] ? 2'd3 : 2'd1; e.count = rs[4:0]; end
                6'd7: begin e.op = 2'd2; e.count = rs[4:0]; end
                default: legal = 1'b0;
            endcase
        end
    endfunction

    function automatic logic [54:0] obs_vec();
        return {in_ready, out_valid, out_data, out_count, out_op, out_rd, illegal_pulse, illegal_cnt};
    endfunction

    function automatic logic [54:0] exp_vec();
        entry_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        return {(m_q.size() < 2) && !rst, m_q.size() > 0, h.data, h.count, h.op, h.rd, m_pulse, 8'(m_cnt)};
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] w;
        int          k;
        logic [5:0]  fl [6];
        fl = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        w = $urandom;
        k = $urandom_range(0, 5);
        w[31:26] = 6'd0;
        w[5:0]   = fl[k];
        return w;
    endfunction

    function automatic logic [31:0] gen_illegal();
        logic [31:0] w;
        logic [5:0]  f;
        w = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            w[31:26] = 6'($urandom_range(1, 63));
        end else begin
            w[31:26] = 6'd0;
            f = 6'($urandom_range(0, 63));
            if (f == 6'd0 || f == 6'd2 || f == 6'd3 || f == 6'd4 || f == 6'd6 || f == 6'd7) f = 6'h20;
            w[5:0] = f;
        end
        return w;
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that edge, then settle 1 time unit.
    task automatic tick();
        logic   legal;
        logic   acc;
        logic   pop;
        entry_t e;
        @(posedge clk);
        ref_decode(instr, rs_val, rt_val, legal, e);
        acc = in_valid && !rst && (m_q.size() < 2);
        pop = out_ready && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (acc && legal) m_q.push_back(e);
        m_pulse = acc && !legal;
        if (acc && !legal && m_cnt < 255) m_cnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
        m_q.delete(); m_pulse = 1'b0; m_cnt = 0;
        #2;
        n_cmp++;
        if (obs_vec() !== 55'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state obs=%h exp=%h", obs_vec(), 55'd0);
        end
        tick();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL after_reset obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_sll();
        in_valid = 1'b1; out_ready = 1'b0;
        instr = {6'd0, 5'd0, 5'd0, 5'd3, 5'd4, 6'b000000};
        rs_val = 32'hDEAD_BEEF; rt_val = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_op, out_count, out_data, out_rd} !== {1'b1, 2'd0, 5'd4, 32'h1, 5'd3}) begin
            n_fail++;
            $display("[TB] FAIL sll_head obs=%b/%0d/%0d/%h/%0d exp=1/0/4/1/3", out_valid, out_op, out_count, out_data, out_rd);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL sll_drain obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_rotrv_srav();
        in_valid = 1'b1; out_ready = 1'b0; rs_val = 32'hFFFF_FFE8; rt_val = 32'h1234_5678;
        instr = {6'd0, 5'd1, 5'd2, 5'd9, 5'b00001, 6'b000110};
        tick();
        n_cmp++;
        if ({out_op, out_count} !== {2'd3, 5'd8}) begin
            n_fail++;
            $display("[TB] FAIL rotrv_head obs=%0d/%0d exp=3/8", out_op, out_count);
        end
        out_ready = 1'b1;
        instr = {6'd0, 5'd1, 5'd2, 5'd10, 5'b00000, 6'b000111};
        rt_val = 32'h8000_0000;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, out_op, out_count, out_rd, out_data} !== {1'b1, 2'd2, 5'd8, 5'd10, 32'h8000_0000}) begin
            n_fail++;
            $display("[TB] FAIL srav_pushpop obs=%b/%0d/%0d/%0d/%h exp=1/2/8/10/80000000", out_valid, out_op, out_count, out_rd, out_data);
        end
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL pushpop_model obs=%h exp=%h", obs_vec(), exp_vec());
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = {6'd0, 5'd0, 5'd0, 5'(i + 1), 5'(i), 6'b000000};
            rt_val = vals[i];
            tick();
            if (i == 2) tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL b2b_push%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_data !== vals[0]) begin
            n_fail++;
            $display("[TB] FAIL b2b_full obs=%b/%h exp=0/%h", in_ready, out_data, vals[0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i >= 1) in_valid = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL b2b_drain%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (i == 0 && out_data !== vals[1]) begin
                n_fail++;
                $display("[TB] FAIL b2b_order obs=%h exp=%h", out_data, vals[1]);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; out_ready = 1'b1;
        instr = {6'h23, 26'h0123456}; rs_val = '0; rt_val = 32'h5;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({illegal_pulse, illegal_cnt, out_valid} !== {1'b1, 8'd1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL lw_reject obs=%b/%0d/%b exp=1/1/0", illegal_pulse, illegal_cnt, out_valid);
        end
        tick();
        n_cmp++;
        if (illegal_pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lw_pulse_width obs=%b exp=0", illegal_pulse);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            instr = gen_illegal();
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL illegal_run%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (illegal_cnt !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL illegal_saturate obs=%0d exp=255", illegal_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            instr = gen_legal(); rs_val = $urandom; rt_val = $urandom;
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        m_q.delete(); m_pulse = 1'b0; m_cnt = 0;
        #1;
        n_cmp++;
        if (obs_vec() !== 55'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset obs=%h exp=%h", obs_vec(), 55'd0);
        end
        #2 rst = 1'b0;
        in_valid = 1'b1; instr = gen_legal(); rs_val = $urandom; rt_val = $urandom;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (obs_vec() !== exp_vec() || out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL post_reset_accept obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            instr     = ($urandom_range(0, 4) == 0) ? gen_illegal() : gen_legal();
            rs_val    = $urandom;
            rt_val    = $urandom;
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_sll();
        test_rotrv_srav();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_issue_queue.md
SHIFT_ISSUE_QUEUE -- requirements
Module: shift_issue_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, shift-count and register-index width.
REQ-003 SHALL have parameters lo_l=0, lo_r=1, al_r=2, ci_r=3, the shifter op encodings driven on out_op.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  instruction/operands offered.
REQ-007 SHALL have port in_ready  output  1  queue can accept this cycle.
REQ-008 SHALL have port instr  input  32  MIPS instruction word.
REQ-009 SHALL have port rs_val  input  DATA_WIDTH  GPR[rs] value.
REQ-010 SHALL have port rt_val  input  DATA_WIDTH  GPR[rt] value.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  downstream shifter stage consumes the head.
REQ-013 SHALL have ports out_data (DATA_WIDTH), out_count (ADDR_WIDTH), out_op (2), out_rd (ADDR_WIDTH), all outputs: head entry data_in, shift_count, op, destination register.
REQ-014 SHALL have ports illegal_pulse  output  1  one-cycle flag for a rejected non-shift instruction, and illegal_cnt  output  8  rejection count.

Function
REQ-015 Decode SHALL apply only when instr[31:26]==0; data=rt_val, rd=instr[15:11] for all legal forms.
REQ-016 funct 000000 (sll) SHALL give op=lo_l, count=instr[10:6].
REQ-017 funct 000010 SHALL give op=lo_r when instr[21]==0 (srl), op=ci_r when instr[21]==1 (rotr); count=instr[10:6].
REQ-018 funct 000011 (sra) SHALL give op=al_r, count=instr[10:6].
REQ-019 funct 000100 (sllv) SHALL give op=lo_l, count=rs_val[4:0]; funct 000111 (srav) op=al_r, count=rs_val[4:0].
REQ-020 funct 000110 SHALL give op=lo_r when instr[6]==0 (srlv), op=ci_r when instr[6]==1 (rotrv); count=rs_val[4:0].
REQ-021 Any other instr (nonzero opcode or other funct) SHALL be illegal: not enqueued, illegal_pulse high the cycle after acceptance, illegal_cnt +1 saturating at 255.
REQ-022 Storage SHALL be a 2-entry FIFO of {data,count,op,rd}; order preserved; occupancy 0..2.
REQ-023 Acceptance SHALL occur on a rising edge with in_valid && in_ready; in_ready = (occupancy<2) && !rst, no same-cycle full bypass.
REQ-024 Illegal instructions SHALL also require in_ready to be accepted (consume a handshake slot, no storage).
REQ-025 Latency SHALL be one cycle: entry accepted at edge N into an empty queue gives out_valid=1 immediately after edge N.
REQ-026 Pop SHALL occur on edge with out_valid && out_ready; simultaneous push and pop with occupancy 1 SHALL leave occupancy 1 with the new entry at head.
REQ-027 Simultaneous push and pop with occupancy 0 SHALL not occur (out_valid=0); push proceeds alone.
REQ-028 out_data/out_count/out_op/out_rd SHALL be 0 when occupancy is 0; held stable while out_valid && !out_ready.
REQ-029 FIFO read/write pointers SHALL be 1-bit, wrapping 1->0.

Reset
REQ-030 rst high SHALL asynchronously clear occupancy, pointers, illegal_cnt, illegal_pulse and all out_* to 0, and force in_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; first edge after deassertion with in_valid SHALL be accepted normally.

Verification
REQ-032 sll rd=3,rt_val=0x0000_0001,shamt=4 -> next cycle out_valid=1, out_op=0, out_count=4, out_data=0x1, out_rd=3.
REQ-033 rotrv (funct 000110, instr[6]=1), rs_val=0xFFFF_FFE8 -> out_op=3, out_count=8; srav with same rs -> out_op=2, out_count=8.
REQ-034 Three back-to-back legal pushes, out_ready=0 -> in_ready=0 after second, third held; raise out_ready -> entries emerge in order, third accepted after first pop.
REQ-035 instr opcode 0x23 (lw) -> no enqueue, illegal_pulse one cycle, illegal_cnt=1; 300 illegals -> illegal_cnt=255.
REQ-036 Occupancy 1, push and pop same edge -> occupancy stays 1, head = new entry; rst pulse with occupancy 2 -> out_valid=0, out_*=0 immediately.
